bullet_pool: RTL and testbench
==============================

Name: bullet_pool

Overview:
- Owns the 10 bullet slots shared by both players: spawns bullets on fire requests, advances them once per frame, retires them at the screen edge or on a hit against the opposing player.
- Produces the per-pixel is_bullet[i] / bullet data nibbles consumed by the colour mapper's bullet selector, plus hit pulses for the HP logic.
- Sits between the player/keyboard logic (upstream) and the colour mapper (downstream).

Parameters:
- NUM_BULLETS, 10, slot count; fixed to match the colour mapper's 10 bullet inputs.
- SPEED, 4, pixels moved per frame tick.
- BULLET_SIZE, 4, bullet sprite width and height in pixels.
- PLAYER_W, 32, player hitbox width.
- PLAYER_H, 48, player hitbox height.
- MUZZLE_Y, 16, vertical spawn offset from the player's top edge.
- SCREEN_W, 640, visible width.
- COOLDOWN, 8, frame ticks a player is blocked after a successful spawn.

Ports:
- Clk, in, 1, system clock (50 MHz).
- Reset, in, 1, asynchronous, active-low; clears all state when 0.
- frame_clk, in, 1, VGA vertical-sync-derived frame strobe; asynchronous level.
- DrawX, in, 10, current pixel x.
- DrawY, in, 10, current pixel y.
- fire1, in, 1, player 1 fire level.
- fire2, in, 1, player 2 fire level.
- p1_x, in, 10, player 1 top-left x.
- p1_y, in, 10, player 1 top-left y.
- p1_dir, in, 1, player 1 facing: 1 = right, 0 = left.
- p2_x, in, 10, player 2 top-left x.
- p2_y, in, 10, player 2 top-left y.
- p2_dir, in, 1, player 2 facing: 1 = right, 0 = left.
- is_bullet, out, 10, bit i = slot i active and covering (DrawX, DrawY).
- bullet_data, out, 40, nibble [4i+3:4i] = palette index for slot i at the current pixel.
- active, out, 10, slot active flags.
- hit1, out, 1, one-cycle pulse: player 1 was hit.
- hit2, out, 1, one-cycle pulse: player 2 was hit.

Behaviour:
- Reset (0): all slots inactive, positions 0, cooldowns 0, edge-detector flops 0, hit1/hit2 = 0, is_bullet = 0, bullet_data = 0. Applies immediately mid-frame. No spawn may occur on the first tick after release unless a fire input is high.
- Tick generation:
  - frame_clk passes through two synchroniser flops and one edge flop.
  - frame_tick is high for exactly one Clk cycle per rising edge of frame_clk; latency is 3 Clk cycles.
  - All slot state changes occur only on the frame_tick cycle.
- Per-slot state: active, x[9:0], y[9:0], dir, owner (0 = player 1, 1 = player 2).
- On frame_tick, for each slot already active before the tick:
  - Compute nx = x + SPEED (dir = 1) or x - SPEED (dir = 0), using 11-bit signed arithmetic.
  - Retire if nx < 0 or nx > SCREEN_W - BULLET_SIZE; otherwise store nx.
  - If not retired, test the nx box (BULLET_SIZE square) for overlap against the opposing player's PLAYER_W x PLAYER_H box. Overlap is inclusive of edge pixels.
  - On overlap: retire the slot and set that player's hit flag.
- Hit outputs: hit1/hit2 are registered and pulse for the cycle after frame_tick. Several bullets hitting the same player on one tick produce a single pulse, and all of those bullets retire.
- Firing (on frame_tick, per player):
  - If cooldown != 0: decrement and reject.
  - Else if fire is high and a free slot exists: spawn and load cooldown = COOLDOWN.
  - Else if no free slot: drop the request; cooldown stays 0 and the player retries next tick.
  - Holding fire therefore spawns every COOLDOWN+1 ticks.
- Slot allocation:
  - Player 1 takes the lowest-index free slot.
  - Player 2 takes the next-lowest free slot.
  - Slots freed on this tick count as free.
  - With only one free slot and both players firing, player 1 wins.
- Spawn position:
  - x = p_x + PLAYER_W if dir = 1, else p_x - BULLET_SIZE.
  - y = p_y + MUZZLE_Y.
  - Spawn is suppressed (treated as no free slot, no cooldown load) if that x is outside 0 to SCREEN_W - BULLET_SIZE.
  - A newly spawned bullet does not move or hit-test on its spawn tick.
- Pixel outputs (combinational from registered state and DrawX/DrawY):
  - Local coordinates: dx = DrawX - x, dy = DrawY - y.
  - is_bullet[i] = active[i] and 0 <= dx, dy < BULLET_SIZE.
  - Sprite pattern by rows, where C = 7 for owner player 1 and C = 15 for owner player 2:
    - row 0: 0 3 3 0
    - row 1: 3 C C 3
    - row 2: 3 C C 3
    - row 3: 0 3 3 0
  - Index 0 is transparent. bullet_data nibble = 0 when is_bullet[i] = 0.

Test Plan:
1. Reset low mid-flight with 3 active slots -> active = 0, is_bullet = 0, hit pulses 0 in the same cycle; after release with fire low, no spawn on the next tick.
2. p1 at (100,200), dir = 1, fire1 high for one tick -> slot 0 active at (132,216); next tick x = 136; pixel (133,216) gives is_bullet[0] = 1, nibble 3; pixel (133,217) gives nibble 7.
3. fire1 held high for 20 ticks -> spawns on ticks 1, 10 and 19 into slots 0, 1, 2.
4. Slots 0-8 busy, fire1 and fire2 on the same tick -> player 1 gets slot 9, player 2 is dropped with cooldown 0 and spawns on the first tick a slot frees.
5. P1 bullet at x = 296 moving right, p2 at (300,184), bullet y = 200 -> on the next tick the slot retires and hit2 pulses exactly one Clk; hit1 stays 0.
6. Bullet at x = 2 moving left -> retires on the next tick with no hit; dir = 1 at x = 636 -> retires on the next tick.

Source files
------------

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - ten shared bullet slots: spawn on fire, advance per frame, retire at edge or on hit.
// Also drives the per-pixel bullet sprite nibbles and registered hit pulses.
module bullet_pool #(
  parameter int NUM_BULLETS = 10,
  parameter int SPEED       = 4,
  parameter int BULLET_SIZE = 4,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 48,
  parameter int MUZZLE_Y    = 16,
  parameter int SCREEN_W    = 640,
  parameter int COOLDOWN    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_clk,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       fire1,
  input  logic                       fire2,
  input  logic [9:0]                 p1_x,
  input  logic [9:0]                 p1_y,
  input  logic                       p1_dir,
  input  logic [9:0]                 p2_x,
  input  logic [9:0]                 p2_y,
  input  logic                       p2_dir,
  output logic [NUM_BULLETS-1:0]     is_bullet,
  output logic [4*NUM_BULLETS-1:0]   bullet_data,
  output logic [NUM_BULLETS-1:0]     active,
  output logic                       hit1,
  output logic                       hit2
);

  localparam logic signed [11:0] SPD   = 12'(SPEED);
  localparam logic signed [11:0] BS    = 12'(BULLET_SIZE);
  localparam logic signed [11:0] PW    = 12'(PLAYER_W);
  localparam logic signed [11:0] PH    = 12'(PLAYER_H);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - BULLET_SIZE);
  localparam logic [9:0]         MZ    = 10'(MUZZLE_Y);
  localparam int                 CW    = $clog2(COOLDOWN + 1);
  localparam logic [NUM_BULLETS-1:0] ONE = NUM_BULLETS'(1);

  logic fs1, fs2, fs3;
  logic frame_tick;

  logic [NUM_BULLETS-1:0] act_q, dir_q, owner_q;
  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [CW-1:0]          cd1, cd2;

  logic signed [11:0]     nx [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] in_rng, strike, survive, hits_p1, hits_p2;
  logic [NUM_BULLETS-1:0] free, free2, p1_oh, p2_oh, p1_take, p2_take;
  logic signed [11:0]     sx1, sx2;
  logic [9:0]             sy1, sy2;
  logic                   p1_try, p2_try, p1_spawn, p2_spawn;

  logic signed [11:0]     dx [NUM_BULLETS];
  logic signed [11:0]     dy [NUM_BULLETS];

  function automatic logic signed [11:0] ext(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction

  // Inclusive box overlap of a bullet square against a player hitbox.
  function automatic logic overlap(input logic signed [11:0] bx, by, px, py);
    return (bx <= px + PW - 12'sd1) && (bx + BS - 12'sd1 >= px) &&
           (by <= py + PH - 12'sd1) && (by + BS - 12'sd1 >= py);
  endfunction

  function automatic logic [3:0] sprite(input logic [1:0] r, c, input logic own);
    logic er, ec;
    er = (r == 2'd0) || (r == 2'd3);
    ec = (c == 2'd0) || (c == 2'd3);
    if (er && ec)
      return 4'd0;
    else if (!er && !ec)
      return own ? 4'd15 : 4'd7;
    else
      return 4'd3;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fs1 <= 1'b0;
      fs2 <= 1'b0;
      fs3 <= 1'b0;
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
    end
  end

  assign frame_tick = fs2 & ~fs3;

  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      nx[i]      = dir_q[i] ? ext(x_q[i]) + SPD : ext(x_q[i]) - SPD;
      in_rng[i]  = (nx[i] >= 12'sd0) && (nx[i] <= X_MAX);
      strike[i]  = owner_q[i] ? overlap(nx[i], ext(y_q[i]), ext(p1_x), ext(p1_y))
                              : overlap(nx[i], ext(y_q[i]), ext(p2_x), ext(p2_y));
      survive[i] = act_q[i] & in_rng[i] & ~strike[i];
      hits_p1[i] = act_q[i] & in_rng[i] & strike[i] & owner_q[i];
      hits_p2[i] = act_q[i] & in_rng[i] & strike[i] & ~owner_q[i];
    end
  end

  // Slots vacated on this tick are reusable immediately; player 1 allocates first.
  always_comb begin
    sx1      = p1_dir ? ext(p1_x) + PW : ext(p1_x) - BS;
    sx2      = p2_dir ? ext(p2_x) + PW : ext(p2_x) - BS;
    sy1      = p1_y + MZ;
    sy2      = p2_y + MZ;
    p1_try   = frame_tick && (cd1 == '0) && fire1 && (sx1 >= 12'sd0) && (sx1 <= X_MAX);
    p2_try   = frame_tick && (cd2 == '0) && fire2 && (sx2 >= 12'sd0) && (sx2 <= X_MAX);
    free     = ~survive;
    p1_oh    = free & (~free + ONE);
    p1_spawn = p1_try && (|free);
    p1_take  = p1_spawn ? p1_oh : '0;
    free2    = free & ~p1_take;
    p2_oh    = free2 & (~free2 + ONE);
    p2_spawn = p2_try && (|free2);
    p2_take  = p2_spawn ? p2_oh : '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      act_q   <= '0;
      dir_q   <= '0;
      owner_q <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (p1_take[i]) begin
          act_q[i]   <= 1'b1;
          x_q[i]     <= sx1[9:0];
          y_q[i]     <= sy1;
          dir_q[i]   <= p1_dir;
          owner_q[i] <= 1'b0;
        end else if (p2_take[i]) begin
          act_q[i]   <= 1'b1;
          x_q[i]     <= sx2[9:0];
          y_q[i]     <= sy2;
          dir_q[i]   <= p2_dir;
          owner_q[i] <= 1'b1;
        end else if (act_q[i]) begin
          act_q[i] <= survive[i];
          if (survive[i])
            x_q[i] <= nx[i][9:0];
        end
      end
    end
  end

  // A request dropped for lack of a slot leaves the cooldown at zero so it retries next tick.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cd1 <= '0;
      cd2 <= '0;
    end else if (frame_tick) begin
      if (cd1 != '0)
        cd1 <= cd1 - CW'(1);
      else if (p1_spawn)
        cd1 <= CW'(COOLDOWN);
      if (cd2 != '0)
        cd2 <= cd2 - CW'(1);
      else if (p2_spawn)
        cd2 <= CW'(COOLDOWN);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hit1 <= 1'b0;
      hit2 <= 1'b0;
    end else begin
      hit1 <= frame_tick & (|hits_p1);
      hit2 <= frame_tick & (|hits_p2);
    end
  end

  assign active = act_q;

  always_comb begin
    is_bullet   = '0;
    bullet_data = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      dx[i] = ext(DrawX) - ext(x_q[i]);
      dy[i] = ext(DrawY) - ext(y_q[i]);
      is_bullet[i] = act_q[i] && (dx[i] >= 12'sd0) && (dx[i] < BS) &&
                     (dy[i] >= 12'sd0) && (dy[i] < BS);
      if (is_bullet[i])
        bullet_data[4*i +: 4] = sprite(dy[i][1:0], dx[i][1:0], owner_q[i]);
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - directed self-checking bench for bullet_pool.
module tb_bullet_pool;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY;
  logic        fire1, fire2;
  logic [9:0]  p1_x, p1_y, p2_x, p2_y;
  logic        p1_dir, p2_dir;
  logic [9:0]  is_bullet;
  logic [39:0] bullet_data;
  logic [9:0]  active;
  logic        hit1, hit2;

  int checks = 0;
  int failures = 0;
  int h1_cnt, h2_cnt;

  bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .fire1(fire1), .fire2(fire2),
    .p1_x(p1_x), .p1_y(p1_y), .p1_dir(p1_dir),
    .p2_x(p2_x), .p2_y(p2_y), .p2_dir(p2_dir),
    .is_bullet(is_bullet), .bullet_data(bullet_data), .active(active),
    .hit1(hit1), .hit2(hit2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_tick;
    h1_cnt = 0;
    h2_cnt = 0;
    frame_clk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk);
      #1;
      if (hit1) h1_cnt++;
      if (hit2) h2_cnt++;
      if (k == 3) frame_clk = 1'b0;
    end
  endtask

  task automatic apply_reset;
    fire1 = 1'b0;
    fire2 = 1'b0;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    DrawX = px;
    DrawY = py;
    #1;
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; fire1 = 1'b0; fire2 = 1'b0;
    DrawX = '0; DrawY = '0;
    p1_x = 10'd100; p1_y = 10'd200; p1_dir = 1'b1;
    p2_x = 10'd500; p2_y = 10'd400; p2_dir = 1'b0;
    #3;
    check("rst_active", active, 10'h000);
    check("rst_hit1", hit1, 1'b0);
    check("rst_hit2", hit2, 1'b0);
    check("rst_isb", is_bullet, 10'h000);
    check("rst_data", bullet_data, 40'h0);
    apply_reset;

    // single spawn, sprite lookup, one step of motion
    fire1 = 1'b1;
    do_tick;
    fire1 = 1'b0;
    check("spawn_active", active, 10'h001);
    pix(10'd133, 10'd216);
    check("spawn_isb", is_bullet, 10'h001);
    check("spawn_nib_edge", bullet_data[3:0], 4'd3);
    pix(10'd133, 10'd217);
    check("spawn_nib_core", bullet_data[3:0], 4'd7);
    do_tick;
    pix(10'd136, 10'd216);
    check("move_isb", is_bullet, 10'h001);
    check("move_nib_corner", bullet_data[3:0], 4'd0);
    pix(10'd137, 10'd217);
    check("move_nib_core", bullet_data[3:0], 4'd7);
    pix(10'd133, 10'd217);
    check("move_old_px", is_bullet, 10'h000);

    // held fire spawns every COOLDOWN+1 ticks
    apply_reset;
    fire1 = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      do_tick;
      if (t == 1)  check("hold_t1", active, 10'h001);
      if (t == 9)  check("hold_t9", active, 10'h001);
      if (t == 10) check("hold_t10", active, 10'h003);
      if (t == 18) check("hold_t18", active, 10'h003);
      if (t == 19) check("hold_t19", active, 10'h007);
    end
    fire1 = 1'b0;

    // asynchronous reset mid-flight
    pix(10'd137, 10'd217);
    check("pre_rst_isb", is_bullet, 10'h004);
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("mid_rst_active", active, 10'h000);
    check("mid_rst_isb", is_bullet, 10'h000);
    check("mid_rst_data", bullet_data, 40'h0);
    check("mid_rst_hits", {hit1, hit2}, 2'b00);
    #3;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    do_tick;
    check("post_rst_nospawn", active, 10'h000);

    // p1 bullet strikes p2
    apply_reset;
    p1_x = 10'd264; p1_y = 10'd184; p1_dir = 1'b1;
    p2_x = 10'd300; p2_y = 10'd184; p2_dir = 1'b0;
    fire1 = 1'b1;
    do_tick;
    fire1 = 1'b0;
    check("hit_spawn_active", active, 10'h001);
    check("hit_spawn_h2", h2_cnt, 0);
    do_tick;
    check("hit_retire", active, 10'h000);
    check("hit2_pulse", h2_cnt, 1);
    check("hit1_quiet", h1_cnt, 0);

    // screen-edge retirement and off-screen spawn suppression
    apply_reset;
    p2_x = 10'd300; p2_y = 10'd400;
    p1_x = 10'd2; p1_y = 10'd300; p1_dir = 1'b0;
    fire1 = 1'b1;
    do_tick;
    check("suppress_spawn", active, 10'h000);
    p1_x = 10'd6;
    do_tick;
    fire1 = 1'b0;
    check("left_spawn", active, 10'h001);
    pix(10'd3, 10'd317);
    check("left_nib", bullet_data[3:0], 4'd7);
    do_tick;
    check("left_retire", active, 10'h000);
    check("left_nohit", h1_cnt + h2_cnt, 0);
    apply_reset;
    p1_x = 10'd604; p1_dir = 1'b1;
    fire1 = 1'b1;
    do_tick;
    fire1 = 1'b0;
    check("right_spawn", active, 10'h001);
    pix(10'd637, 10'd317);
    check("right_nib", bullet_data[3:0], 4'd7);
    do_tick;
    check("right_retire", active, 10'h000);

    // pool exhaustion: p1 takes the last slot, p2 retries until one frees
    apply_reset;
    p1_x = 10'd0;   p1_y = 10'd0;   p1_dir = 1'b1;
    p2_x = 10'd600; p2_y = 10'd400; p2_dir = 1'b0;
    for (int t = 1; t <= 151; t++) begin
      fire1 = (t <= 37) || (t == 46);
      fire2 = (t <= 28) || (t >= 46);
      do_tick;
      if (t == 37) check("full_t37", active, 10'h1FF);
      if (t == 46) begin
        check("full_t46", active, 10'h3FF);
        pix(10'd33, 10'd17);
        check("p1_last_slot", is_bullet, 10'h200);
        check("p1_last_nib", bullet_data[39:36], 4'd7);
      end
      if (t == 150) check("full_t150", active, 10'h3FF);
      if (t == 151) begin
        check("refill_active", active, 10'h3FF);
        pix(10'd597, 10'd417);
        check("p2_refill_slot", is_bullet, 10'h002);
        check("p2_refill_nib", bullet_data[7:4], 4'd15);
        check("full_nohit", h1_cnt + h2_cnt, 0);
      end
    end
    fire1 = 1'b0;
    fire2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
